// File: rtl/hazard_if.sv
// Pipeline-to-hazard-controller signal bundle: hazard sources from ID/EX/MEM
// toward the controller, stage hold/stall/flush controls back to the pipeline.
interface hazard_if;
    logic [3:0] id_raddr1;
    logic [3:0] id_raddr2;
    logic       id_ruse1;
    logic       id_ruse2;
    logic [3:0] ex_waddr;
    logic       ex_rfwen;
    logic       ex_memrd;
    logic       ex_branch_taken;
    logic       mem_req;
    logic       mem_ready;
    logic       pc_hold;
    logic       ifid_hold;
    logic       ifid_flush;
    logic       idex_stall;
    logic       idex_flush;
    logic       exmem_hold;
    logic       memwb_bubble;
    logic       mem_timeout;
    logic [1:0] state;

    modport master (
        output id_raddr1, id_raddr2, id_ruse1, id_ruse2, ex_waddr, ex_rfwen,
               ex_memrd, ex_branch_taken, mem_req, mem_ready,
        input  pc_hold, ifid_hold, ifid_flush, idex_stall, idex_flush,
               exmem_hold, memwb_bubble, mem_timeout, state
    );

    modport slave (
        input  id_raddr1, id_raddr2, id_ruse1, id_ruse2, ex_waddr, ex_rfwen,
               ex_memrd, ex_branch_taken, mem_req, mem_ready,
        output pc_hold, ifid_hold, ifid_flush, idex_stall, idex_flush,
               exmem_hold, memwb_bubble, mem_timeout, state
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard/stall controller for the five-stage CPU: memory wait > branch flush > load-use.
// Optional HAZARD_PERF_CNT_EN adds saturating stall_cnt / flush_cnt outputs.
module hazard_ctrl #(
    parameter int         FLUSH_CYCLES = 1,
    parameter int         MEM_TIMEOUT  = 255,
    parameter logic [3:0] NOREG        = 4'hF
) (
    input  logic        clk,
    input  logic        rst,
`ifdef HAZARD_PERF_CNT_EN
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt,
`endif
    hazard_if.slave     hz
);
    localparam int            TW          = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TW-1:0] TIMEOUT_VAL = TW'(MEM_TIMEOUT);
    localparam logic [2:0]    FLUSH_LAST  = 3'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEMWAIT  = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    state_t        state_reg, state_next;
    logic [2:0]    redirect_cnt_reg, redirect_cnt_next;
    logic [TW-1:0] wait_cnt_reg, wait_cnt_next;
    logic          timeout_reg, timeout_next;
    logic          mem_wait, branch_flush, load_use;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= RUN;
            redirect_cnt_reg <= '0;
            wait_cnt_reg     <= '0;
            timeout_reg      <= 1'b0;
        end else begin
            state_reg        <= state_next;
            redirect_cnt_reg <= redirect_cnt_next;
            wait_cnt_reg     <= wait_cnt_next;
            timeout_reg      <= timeout_next;
        end
    end

    always_comb begin
        state_next        = state_reg;
        redirect_cnt_next = redirect_cnt_reg;
        wait_cnt_next     = wait_cnt_reg;
        timeout_next      = timeout_reg;
        hz.pc_hold        = 1'b0;
        hz.ifid_hold      = 1'b0;
        hz.ifid_flush     = 1'b0;
        hz.idex_stall     = 1'b0;
        hz.idex_flush     = 1'b0;
        hz.exmem_hold     = 1'b0;
        hz.memwb_bubble   = 1'b0;

        mem_wait     = hz.mem_req & ~hz.mem_ready;
        branch_flush = ~mem_wait & (((state_reg == RUN) & hz.ex_branch_taken) |
                                    (state_reg == REDIRECT));
        load_use     = hz.ex_rfwen & hz.ex_memrd & (hz.ex_waddr != NOREG) &
                       ((hz.id_ruse1 & (hz.id_raddr1 == hz.ex_waddr)) |
                        (hz.id_ruse2 & (hz.id_raddr2 == hz.ex_waddr)));

        case (state_reg)
            RUN: begin
                if (mem_wait) begin
                    state_next = MEMWAIT;
                end else if (hz.ex_branch_taken && FLUSH_CYCLES > 1) begin
                    state_next        = REDIRECT;
                    redirect_cnt_next = '0;
                end
            end
            MEMWAIT: begin
                if (hz.mem_ready) begin
                    state_next    = RUN;
                    wait_cnt_next = '0;
                end else if (wait_cnt_reg != TIMEOUT_VAL) begin
                    // Counter saturates so a long wait cannot wrap it.
                    wait_cnt_next = wait_cnt_reg + TW'(1);
                    if (wait_cnt_next == TIMEOUT_VAL)
                        timeout_next = 1'b1;
                end
            end
            REDIRECT: begin
                // A stalled pipeline does not consume flush cycles.
                if (!mem_wait) begin
                    if (3'(redirect_cnt_reg + 3'd1) == FLUSH_LAST) begin
                        state_next        = RUN;
                        redirect_cnt_next = '0;
                    end else begin
                        redirect_cnt_next = redirect_cnt_reg + 3'd1;
                    end
                end
            end
            default: state_next = RUN;
        endcase

        if (!rst) begin
            if (mem_wait) begin
                hz.pc_hold      = 1'b1;
                hz.ifid_hold    = 1'b1;
                hz.exmem_hold   = 1'b1;
                hz.memwb_bubble = 1'b1;
            end else if (branch_flush) begin
                hz.ifid_flush = 1'b1;
                hz.idex_flush = 1'b1;
            end else if (load_use) begin
                hz.pc_hold    = 1'b1;
                hz.ifid_hold  = 1'b1;
                hz.idex_stall = 1'b1;
            end
        end
    end

    assign hz.mem_timeout = timeout_reg & ~rst;
    assign hz.state       = rst ? 2'd0 : state_reg;

`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] stall_cnt_reg, flush_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            if (hz.pc_hold && stall_cnt_reg != 16'hFFFF)
                stall_cnt_reg <= stall_cnt_reg + 16'd1;
            if (hz.idex_flush && flush_cnt_reg != 16'hFFFF)
                flush_cnt_reg <= flush_cnt_reg + 16'd1;
        end
    end

    assign stall_cnt = rst ? 16'd0 : stall_cnt_reg;
    assign flush_cnt = rst ? 16'd0 : flush_cnt_reg;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized and directed bench for hazard_ctrl, checked cycle by cycle
// against a behavioural model of the stall/flush rules.
module tb_hazard_ctrl;
    localparam int FLUSH_CYCLES = 2;
    localparam int MEM_TIMEOUT  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    hazard_if hif ();

    hazard_ctrl #(
        .FLUSH_CYCLES (FLUSH_CYCLES),
        .MEM_TIMEOUT  (MEM_TIMEOUT),
        .NOREG        (4'hF)
    ) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef HAZARD_PERF_CNT_EN
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt),
`endif
        .hz        (hif.slave)
    );

`ifndef HAZARD_PERF_CNT_EN
    assign stall_cnt = 16'd0;
    assign flush_cnt = 16'd0;
`endif

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Model state: plain counts of outstanding work rather than an FSM.
    bit in_wait      = 1'b0;
    int flush_left   = 0;
    int wait_cycles  = 0;
    bit tmo          = 1'b0;
    int stall_total  = 0;
    int flush_total  = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic set_idle();
        rst                 = 1'b0;
        hif.id_raddr1       = 4'd0;
        hif.id_raddr2       = 4'd0;
        hif.id_ruse1        = 1'b0;
        hif.id_ruse2        = 1'b0;
        hif.ex_waddr        = 4'd0;
        hif.ex_rfwen        = 1'b0;
        hif.ex_memrd        = 1'b0;
        hif.ex_branch_taken = 1'b0;
        hif.mem_req         = 1'b0;
        hif.mem_ready       = 1'b0;
    endtask

    task automatic set_load_use(input logic [3:0] waddr);
        hif.ex_rfwen = 1'b1;
        hif.ex_memrd = 1'b1;
        hif.ex_waddr = waddr;
        hif.id_ruse2 = 1'b1;
        hif.id_raddr2 = 4'd3;
    endtask

    // Evaluate one cycle: check outputs at negedge, advance model at posedge.
    task automatic run_cycle();
        bit mw, br, lu;
        bit e_pc, e_ifh, e_iff, e_ids, e_idf, e_exh, e_mwb;
        int e_state;
        @(negedge clk);
        mw = hif.mem_req && !hif.mem_ready;
        br = !mw && ((!in_wait && flush_left == 0 && hif.ex_branch_taken) || flush_left > 0);
        lu = hif.ex_rfwen && hif.ex_memrd && hif.ex_waddr != 4'hF &&
             ((hif.id_ruse1 && hif.id_raddr1 == hif.ex_waddr) ||
              (hif.id_ruse2 && hif.id_raddr2 == hif.ex_waddr));
        {e_pc, e_ifh, e_iff, e_ids, e_idf, e_exh, e_mwb} = '0;
        if (!rst) begin
            if (mw)      begin e_pc = 1; e_ifh = 1; e_exh = 1; e_mwb = 1; end
            else if (br) begin e_iff = 1; e_idf = 1; end
            else if (lu) begin e_pc = 1; e_ifh = 1; e_ids = 1; end
        end
        e_state = rst ? 0 : (in_wait ? 1 : (flush_left > 0 ? 2 : 0));

        check_eq("ctl", 32'({hif.pc_hold, hif.ifid_hold, hif.ifid_flush, hif.idex_stall,
                             hif.idex_flush, hif.exmem_hold, hif.memwb_bubble}),
                 32'({e_pc, e_ifh, e_iff, e_ids, e_idf, e_exh, e_mwb}));
        check_eq("state", 32'(hif.state), 32'(e_state));
        check_eq("timeout", 32'(hif.mem_timeout), 32'(tmo && !rst));
`ifdef HAZARD_PERF_CNT_EN
        check_eq("stall_cnt", 32'(stall_cnt), rst ? 32'd0 : 32'(stall_total));
        check_eq("flush_cnt", 32'(flush_cnt), rst ? 32'd0 : 32'(flush_total));
`endif
        $display("cyc %0d rst=%0b req=%0b rdy=%0b br=%0b ctl=%b state=%0d tmo=%0b",
                 cyc, rst, hif.mem_req, hif.mem_ready, hif.ex_branch_taken,
                 {hif.pc_hold, hif.ifid_hold, hif.ifid_flush, hif.idex_stall,
                  hif.idex_flush, hif.exmem_hold, hif.memwb_bubble}, hif.state, hif.mem_timeout);

        @(posedge clk);
        if (rst) begin
            in_wait = 0; flush_left = 0; wait_cycles = 0; tmo = 0;
            stall_total = 0; flush_total = 0;
        end else begin
            if (e_pc && stall_total < 65535) stall_total++;
            if (e_idf && flush_total < 65535) flush_total++;
            if (in_wait) begin
                if (hif.mem_ready) begin
                    in_wait = 0; wait_cycles = 0;
                end else if (wait_cycles < MEM_TIMEOUT) begin
                    wait_cycles++;
                    if (wait_cycles == MEM_TIMEOUT) tmo = 1;
                end
            end else if (flush_left > 0) begin
                if (!mw) flush_left--;
            end else if (mw) begin
                in_wait = 1;
            end else if (hif.ex_branch_taken) begin
                flush_left = FLUSH_CYCLES - 1;
            end
        end
        cyc++;
        #1;
    endtask

    bit prev_mw;

    initial begin
        set_idle();
        rst = 1'b1;
        #1;
        run_cycle();
        // Reset with hazards asserted.
        hif.ex_branch_taken = 1; hif.mem_req = 1;
        repeat (2) run_cycle();
        set_idle(); run_cycle();
        // Load-use hit, then NOREG destination.
        set_load_use(4'd3); run_cycle();
        set_idle(); run_cycle();
        set_load_use(4'hF); run_cycle();
        set_idle(); run_cycle();
        // Branch pulse, second taken in REDIRECT must not extend.
        hif.ex_branch_taken = 1; run_cycle();
        run_cycle();
        set_idle(); repeat (2) run_cycle();
        // Three-cycle memory wait with a load-use hazard inside.
        hif.mem_req = 1; set_load_use(4'd3); repeat (3) run_cycle();
        hif.mem_ready = 1; run_cycle();
        set_idle(); run_cycle();
        // Branch held through a two-cycle wait.
        hif.ex_branch_taken = 1; hif.mem_req = 1; repeat (2) run_cycle();
        hif.mem_ready = 1; run_cycle();
        hif.mem_req = 0; hif.mem_ready = 0; run_cycle();
        set_idle(); repeat (2) run_cycle();
        // Timeout after a six-cycle wait, sticky until reset.
        rst = 1; run_cycle();
        set_idle(); hif.mem_req = 1; repeat (6) run_cycle();
        hif.mem_ready = 1; run_cycle();
        set_idle(); repeat (3) run_cycle();
        rst = 1; run_cycle();
        set_idle(); run_cycle();

        // Random traffic; a pending memory request is held until ready.
        prev_mw = 0;
        for (int i = 0; i < 800; i++) begin
            rst                 = ($urandom_range(0, 79) == 0);
            hif.id_raddr1       = 4'($urandom_range(0, 4));
            hif.id_raddr2       = 4'($urandom_range(0, 4));
            hif.id_ruse1        = 1'($urandom);
            hif.id_ruse2        = 1'($urandom);
            hif.ex_waddr        = ($urandom_range(0, 5) == 0) ? 4'hF : 4'($urandom_range(0, 4));
            hif.ex_rfwen        = 1'($urandom);
            hif.ex_memrd        = 1'($urandom);
            hif.ex_branch_taken = ($urandom_range(0, 5) == 0);
            hif.mem_req         = prev_mw || ($urandom_range(0, 3) == 0);
            hif.mem_ready       = ($urandom_range(0, 2) == 0);
            prev_mw = !rst && hif.mem_req && !hif.mem_ready;
            run_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the 16-bit five-stage CPU. It sits beside the ID/EX register and drives the hold, stall and flush controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB stages. It resolves three cases: load-use hazards, taken-branch redirects and data-memory wait states. Outputs are Mealy functions of a registered FSM plus current-cycle pipeline inputs, so a hazard is acted on in the cycle it appears.

## Interface
- FLUSH_CYCLES, 1: cycles of IF/ID and ID/EX flush after a taken branch (1..7)
- MEM_TIMEOUT, 255: MEMWAIT cycles before mem_timeout is raised (1..65535)
- NOREG, 4'hF: register address meaning "no register"; never matches
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- id_raddr1, id_raddr2  in  4  source register addresses of the instruction in ID
- id_ruse1, id_ruse2  in  1  ID instruction actually reads raddr1 / raddr2
- ex_waddr  in  4  destination register of the instruction in EX
- ex_rfwen  in  1  EX instruction writes the register file
- ex_memrd  in  1  EX instruction is a load (write data comes from data memory)
- ex_branch_taken  in  1  branch/jump resolved taken in EX this cycle
- mem_req  in  1  MEM-stage instruction accesses data memory
- mem_ready  in  1  data memory completes the access this cycle
- pc_hold  out  1  PC keeps its value
- ifid_hold  out  1  IF/ID keeps its contents
- ifid_flush  out  1  IF/ID loads a bubble
- idex_stall  out  1  ID/EX loads a bubble, marked as stall-generated
- idex_flush  out  1  ID/EX marks the incoming entry as flushed
- exmem_hold  out  1  EX/MEM keeps its contents (ID/EX also holds when this is high)
- memwb_bubble  out  1  MEM/WB loads a bubble
- mem_timeout  out  1  sticky: a memory wait exceeded MEM_TIMEOUT
- state  out  2  FSM state: 0 RUN, 1 MEMWAIT, 2 REDIRECT

## Operation
- States and transitions:
  - RUN → MEMWAIT when mem_req & !mem_ready.
  - RUN → REDIRECT when ex_branch_taken with no memory wait and FLUSH_CYCLES > 1.
  - MEMWAIT → RUN on mem_ready.
  - REDIRECT → RUN when the flush counter reaches FLUSH_CYCLES-1.
- Priority, highest first: memory wait, then branch flush, then load-use.
- Memory wait is active when mem_req & !mem_ready, in any state. It asserts pc_hold, ifid_hold, exmem_hold and memwb_bubble, and forces every other control to 0.
- Branch flush (no memory wait, ex_branch_taken in RUN) asserts ifid_flush and idex_flush. REDIRECT keeps both asserted for the remaining FLUSH_CYCLES-1 cycles. ex_branch_taken is ignored inside REDIRECT.
- Load-use: ex_rfwen & ex_memrd & ex_waddr≠NOREG & ((id_ruse1 & id_raddr1==ex_waddr) | (id_ruse2 & id_raddr2==ex_waddr)). It asserts pc_hold, ifid_hold and idex_stall for exactly that cycle. It is suppressed by a memory wait or a branch flush.
- A branch that coincides with a memory wait is not lost. EX is frozen, so ex_branch_taken is seen again in the first cycle after mem_ready.
- Timeout counter:
  - Width is clog2(MEM_TIMEOUT+1). It increments each MEMWAIT cycle and clears on MEMWAIT exit.
  - When it equals MEM_TIMEOUT, mem_timeout sets and stays set until rst. Holds continue; there is no abort.
- Flush counter: 3 bits, cleared on REDIRECT entry.

## Timing
- Zero-cycle latency: hazard inputs affect outputs combinationally in the same cycle. State and counters update on posedge clk.
- Reset: rst high forces every output to 0, state to RUN, all counters to 0, mem_timeout to 0. Outputs read 0 during the reset cycle, regardless of inputs.
- Reset mid-MEMWAIT or mid-REDIRECT aborts the sequence. Only RUN behaviour applies after rst drops.
- mem_req & mem_ready in the same cycle is a zero-wait access: no hold, and the FSM stays in RUN.
- MEMWAIT lasting N cycles holds for exactly N cycles. The cycle with mem_ready has no hold.

## Configuration
- HAZARD_PERF_CNT_EN defined adds two 16-bit outputs:
  - stall_cnt: counts cycles with pc_hold high.
  - flush_cnt: counts cycles with idex_flush high.
  - Both saturate at 16'hFFFF and clear on rst.
- Undefined: those ports and counters do not exist, and behaviour is otherwise identical.

## Test plan
- Reset: rst=1 for 2 cycles with ex_branch_taken=1 and mem_req=1, mem_ready=0 → all outputs 0, state=0.
- Load-use: ex_rfwen=1, ex_memrd=1, ex_waddr=3, id_ruse2=1, id_raddr2=3 for one cycle → pc_hold=ifid_hold=idex_stall=1 that cycle only. The same stimulus with ex_waddr=4'hF → no stall.
- Branch with FLUSH_CYCLES=2: ex_branch_taken pulse → ifid_flush=idex_flush=1 for 2 cycles, state 2 then 0. A second ex_branch_taken in the second cycle does not extend the flush.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles then 1 → pc_hold=exmem_hold=memwb_bubble=1 for 3 cycles, 0 in the mem_ready cycle. A load-use hazard during the wait yields idex_stall=0.
- Branch during wait: ex_branch_taken=1 held through a 2-cycle wait → no flush during the wait, flush in the cycle after mem_ready.
- Timeout with MEM_TIMEOUT=4: 6-cycle wait → mem_timeout rises after the 4th MEMWAIT cycle and stays 1 until rst. With HAZARD_PERF_CNT_EN, stall_cnt=6.
